// File: rtl/coin_acceptor_if.sv
// Sensor-side and FSM-side signal bundle of the coin acceptor.
// The slave modport is the acceptor itself; the master modport is the environment driving the sensors.
interface coin_acceptor_if;
    logic [2:0] sense;
    logic [1:0] coin;
    logic       reject;
    logic       busy;
    logic [7:0] tally_a;
    logic [7:0] tally_b;
    logic [7:0] tally_c;

    modport master (
        output sense,
        input  coin, reject, busy, tally_a, tally_b, tally_c
    );

    modport slave (
        input  sense,
        output coin, reject, busy, tally_a, tally_b, tally_c
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces three coin sensors and emits one coin-code pulse per coin.
// Defining COIN_TALLY_EN builds saturating per-coin tallies; otherwise the tallies read 8'h00.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic           clock,
    input  logic           reset,
    coin_acceptor_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_EMIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Non-one-hot patterns map to 2'b00, which the EMIT state treats as a jam.
    function automatic logic [1:0] coin_code(input logic [2:0] pat);
        case (pat)
            3'b001:  coin_code = 2'b01;
            3'b010:  coin_code = 2'b10;
            3'b100:  coin_code = 2'b11;
            default: coin_code = 2'b00;
        endcase
    endfunction

    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    state_t        state_r;
    logic [2:0]    pat_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    coin_r;
    logic          reject_r;

    // Two-flop synchronizer on the raw sensors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= bus.sense;
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM with registered single-cycle coin/reject pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            pat_r    <= 3'b000;
            cnt_r    <= '0;
            coin_r   <= 2'b00;
            reject_r <= 1'b0;
        end else begin
            coin_r   <= 2'b00;
            reject_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sync2_r != 3'b000) begin
                        pat_r   <= sync2_r;
                        cnt_r   <= CNT_ONE;
                        state_r <= ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    // Any deviation from the latched pattern is a glitch: drop it silently.
                    if (sync2_r != pat_r) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_EMIT;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_EMIT: begin
                    if (coin_code(pat_r) != 2'b00) begin
                        coin_r <= coin_code(pat_r);
                    end else begin
                        reject_r <= 1'b1;
                    end
                    cnt_r   <= '0;
                    state_r <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Sensor activity restarts the release window, so a bouncing coin yields one pulse.
                    if (sync2_r != 3'b000) begin
                        cnt_r <= '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign bus.coin   = coin_r;
    assign bus.reject = reject_r;
    assign bus.busy   = (state_r != ST_IDLE);

`ifdef COIN_TALLY_EN
    logic [7:0] tally_a_r;
    logic [7:0] tally_b_r;
    logic [7:0] tally_c_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // Tallies step on the same edge that launches the coin pulse and hold at 8'hFF.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tally_a_r <= 8'h00;
            tally_b_r <= 8'h00;
            tally_c_r <= 8'h00;
        end else if (state_r == ST_EMIT) begin
            case (pat_r)
                3'b001:  tally_a_r <= sat_inc(tally_a_r);
                3'b010:  tally_b_r <= sat_inc(tally_b_r);
                3'b100:  tally_c_r <= sat_inc(tally_c_r);
                default: tally_a_r <= tally_a_r;
            endcase
        end
    end

    assign bus.tally_a = tally_a_r;
    assign bus.tally_b = tally_b_r;
    assign bus.tally_c = tally_c_r;
`else
    assign bus.tally_a = 8'h00;
    assign bus.tally_b = 8'h00;
    assign bus.tally_c = 8'h00;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with DEBOUNCE_CYCLES=4.
// Tally expectations follow COIN_TALLY_EN: counts saturating at 8'hFF when defined, 8'h00 otherwise.
module tb_coin_acceptor;
    logic clock = 1'b0;
    logic reset;

    coin_acceptor_if bus ();

    coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef COIN_TALLY_EN
    localparam bit TALLY_ON = 1'b1;
`else
    localparam bit TALLY_ON = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] wave [0:63];
    int         pulses;
    int         first_edge;
    int         rejects;
    logic [1:0] last_code;
    int         exp_a;
    int         exp_b;
    int         exp_c;

    function automatic logic [7:0] tally_exp(input int n);
        if (!TALLY_ON) return 8'h00;
        if (n > 255) return 8'hFF;
        return 8'(n);
    endfunction

    task automatic fill(input int start, input int len, input logic [2:0] val);
        for (int i = start; i < start + len; i++) wave[i] = val;
    endtask

    // Entry i is applied before edge i; outputs are observed at the negedge after edge i.
    task automatic run_wave(input int len);
        pulses = 0; first_edge = -1; rejects = 0; last_code = 2'b00;
        for (int i = 0; i < len; i++) begin
            bus.sense = wave[i];
            @(negedge clock);
            if (bus.coin != 2'b00) begin
                pulses++;
                last_code = bus.coin;
                if (first_edge < 0) first_edge = i;
            end
            if (bus.reject) rejects++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.sense = 3'b000;
        @(negedge clock);
        n_cmp++; if (bus.coin !== 2'b00) begin n_bad++; $display("FAIL reset_coin: got %b want 00", bus.coin); end
        n_cmp++; if (bus.reject !== 1'b0) begin n_bad++; $display("FAIL reset_reject: got %b want 0", bus.reject); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.tally_a !== 8'h00) begin n_bad++; $display("FAIL reset_tally_a: got %h want 00", bus.tally_a); end
        reset = 1'b0;
        exp_a = 0; exp_b = 0; exp_c = 0;
        @(negedge clock);
    endtask

    task automatic test_clean_b;
        fill(0, 12, 3'b010);
        fill(12, 14, 3'b000);
        run_wave(26);
        exp_b++;
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL clean_pulses: got %0d want 1", pulses); end
        n_cmp++; if (first_edge !== 6) begin n_bad++; $display("FAIL clean_latency: got edge %0d want 6", first_edge); end
        n_cmp++; if (last_code !== 2'b10) begin n_bad++; $display("FAIL clean_code: got %b want 10", last_code); end
        n_cmp++; if (rejects !== 0) begin n_bad++; $display("FAIL clean_reject: got %0d want 0", rejects); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL clean_idle: busy %b want 0", bus.busy); end
        n_cmp++; if (bus.tally_b !== tally_exp(exp_b)) begin n_bad++; $display("FAIL clean_tally_b: got %h want %h", bus.tally_b, tally_exp(exp_b)); end
    endtask

    task automatic test_bounce;
        wave[0] = 3'b001; wave[1] = 3'b000;
        fill(2, 11, 3'b001);
        fill(13, 14, 3'b000);
        run_wave(27);
        exp_a++;
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
        n_cmp++; if (last_code !== 2'b01) begin n_bad++; $display("FAIL bounce_code: got %b want 01", last_code); end
        n_cmp++; if (first_edge !== 8) begin n_bad++; $display("FAIL bounce_latency: got edge %0d want 8", first_edge); end
        fill(0, 2, 3'b001);
        fill(2, 10, 3'b000);
        run_wave(12);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_jam;
        fill(0, 10, 3'b101);
        fill(10, 14, 3'b000);
        run_wave(24);
        n_cmp++; if (rejects !== 1) begin n_bad++; $display("FAIL jam_reject: got %0d want 1", rejects); end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL jam_coin: got %0d pulses want 0", pulses); end
        n_cmp++; if (bus.tally_a !== tally_exp(exp_a)) begin n_bad++; $display("FAIL jam_tally_a: got %h want %h", bus.tally_a, tally_exp(exp_a)); end
        n_cmp++; if (bus.tally_c !== tally_exp(exp_c)) begin n_bad++; $display("FAIL jam_tally_c: got %h want %h", bus.tally_c, tally_exp(exp_c)); end
    endtask

    task automatic test_release_gating;
        fill(0, 8, 3'b100);
        fill(8, 2, 3'b000);
        fill(10, 8, 3'b100);
        fill(18, 14, 3'b000);
        run_wave(32);
        exp_c++;
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL gate_pulses: got %0d want 1", pulses); end
        n_cmp++; if (last_code !== 2'b11) begin n_bad++; $display("FAIL gate_code: got %b want 11", last_code); end
        fill(0, 8, 3'b100);
        fill(8, 14, 3'b000);
        run_wave(22);
        exp_c++;
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL gate_second: got %0d want 1", pulses); end
        n_cmp++; if (bus.tally_c !== tally_exp(exp_c)) begin n_bad++; $display("FAIL gate_tally_c: got %h want %h", bus.tally_c, tally_exp(exp_c)); end
    endtask

    task automatic test_reset_mid;
        fill(0, 4, 3'b010);
        run_wave(4);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", bus.busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.coin !== 2'b00) begin n_bad++; $display("FAIL mid_coin: got %b want 00", bus.coin); end
        n_cmp++; if (bus.tally_b !== 8'h00) begin n_bad++; $display("FAIL mid_tally_b: got %h want 00", bus.tally_b); end
        exp_a = 0; exp_b = 0; exp_c = 0;
        @(negedge clock);
        @(negedge clock);
        bus.sense = 3'b000;
        reset = 1'b0;
        fill(0, 15, 3'b000);
        run_wave(15);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_no_coin: got %0d pulses want 0", pulses); end
        fill(0, 8, 3'b010);
        fill(8, 12, 3'b000);
        run_wave(20);
        exp_b++;
        n_cmp++; if (pulses !== 1 || last_code !== 2'b10) begin n_bad++; $display("FAIL mid_new_press: got %0d pulses code %b want 1 code 10", pulses, last_code); end
    endtask

    task automatic test_tally;
        int total;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_a = 0; exp_b = 0; exp_c = 0;
        total = 0;
        fill(0, 6, 3'b001);
        fill(6, 10, 3'b000);
        for (int k = 1; k <= 300; k++) begin
            run_wave(16);
            total += pulses;
            exp_a++;
            if (k == 254 || k == 255) begin
                n_cmp++; if (bus.tally_a !== tally_exp(k)) begin n_bad++; $display("FAIL tally_a_at_%0d: got %h want %h", k, bus.tally_a, tally_exp(k)); end
            end
        end
        n_cmp++; if (total !== 300) begin n_bad++; $display("FAIL tally_pulses: got %0d want 300", total); end
        n_cmp++; if (bus.tally_a !== tally_exp(exp_a)) begin n_bad++; $display("FAIL tally_a_sat: got %h want %h", bus.tally_a, tally_exp(exp_a)); end
        n_cmp++; if (bus.tally_b !== 8'h00) begin n_bad++; $display("FAIL tally_b: got %h want 00", bus.tally_b); end
        n_cmp++; if (bus.tally_c !== 8'h00) begin n_bad++; $display("FAIL tally_c: got %h want 00", bus.tally_c); end
    endtask

    initial begin
        reset = 1'b1;
        bus.sense = 3'b000;
        @(negedge clock);
        test_reset;
        test_clean_b;
        test_bounce;
        test_jam;
        test_release_gating;
        test_reset_mid;
        test_tally;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
